// File: rtl/fsb_arbiter.sv
// ---------------------------------------------------------------------------
// fsb_arbiter
//
// Two-requester front-side bus arbiter. The instruction-cache (i_*) and
// data-cache (d_*) miss paths compete for the single memory-side bus (m_*).
// The winner owns the bus for one fixed-length burst of BLOCK_WORDS word
// beats. The burst ends after its final beat or when the core raises abort_bus.
// Every burst is followed by at least one idle cycle.
//
// Parameters:
//   BLOCK_WORDS  words per burst (power of two, 1..8)
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   abort_bus            cancel the in-flight burst
//   i_req / d_req        requests, held by the requester until done
//   i_wen / d_wen        1 = writeback burst, 0 = fill burst
//   i_addr / d_addr      block address (low offset bits ignored)
//   i_wdata / d_wdata    current write beat data from each requester
//   i_gnt / d_gnt        requester owns the bus
//   i_beat / d_beat      beat accepted this cycle
//   i_done / d_done      one-cycle pulse on the final beat
//   rdata                shared read data (memory passthrough on a beat)
//   m_req, m_wen,        memory request, write enable, beat address and
//   m_addr, m_wdata      beat write data
//   m_ready, m_rdata     memory beat completion and read data
//
// Configuration macro:
//   FSB_ARB_ROUND_ROBIN_EN  defined   -> round-robin tie break (the
//                                        requester that did not win last
//                                        time wins a tie)
//                           undefined -> fixed priority, dcache wins ties
// ---------------------------------------------------------------------------
module fsb_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              abort_bus,
  input  logic              i_req,
  input  logic              d_req,
  input  logic              i_wen,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_beat,
  output logic              d_beat,
  output logic              i_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              m_req,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int OFF_W = $clog2(BLOCK_WORDS * 4);
  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_next_base;
  logic              r_wen;
  logic              w_next_wen;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;

  logic              w_busy;
  logic              w_beat;
  logic              w_last;
  logic              w_pick_d;
  logic [ADDR_W-1:0] w_offset;

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_beat = w_busy && m_ready;
  assign w_last = w_beat && (r_cnt == LAST_BEAT);

`ifdef FSB_ARB_ROUND_ROBIN_EN
  // r_last_d remembers who won the most recent grant (1 = dcache). Reset
  // says icache, so the first tie goes to the dcache.
  logic r_last_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
    end else if ((r_state == IDLE) && (w_next_state != IDLE)) begin
      r_last_d <= (w_next_state == BUSY_D);
    end
  end

  assign w_pick_d = d_req && (!i_req || !r_last_d);
`else
  assign w_pick_d = d_req;
`endif

  // Beat offset is OR-ed onto the aligned base, so beat addresses can never
  // carry out of the block.
  assign w_offset = ADDR_W'({r_cnt, 2'b00});

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_wen   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_base  <= w_next_base;
      r_wen   <= w_next_wen;
      r_cnt   <= w_next_cnt;
    end
  end

  // An abort in IDLE suppresses the grant for one cycle. In a burst the final
  // beat takes precedence over a coincident abort, so the done pulse is never
  // lost.
  always_comb begin
    w_next_state = r_state;
    w_next_base  = r_base;
    w_next_wen   = r_wen;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (!abort_bus && (i_req || d_req)) begin
          w_next_cnt = '0;
          if (w_pick_d) begin
            w_next_state = BUSY_D;
            w_next_base  = d_addr & BASE_MASK;
            w_next_wen   = d_wen;
          end else begin
            w_next_state = BUSY_I;
            w_next_base  = i_addr & BASE_MASK;
            w_next_wen   = i_wen;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (w_last) begin
          w_next_state = IDLE;
        end else if (abort_bus) begin
          w_next_state = IDLE;
        end else if (w_beat) begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign m_req   = w_busy;
  assign m_wen   = w_busy && r_wen;
  assign m_addr  = w_busy ? (r_base | w_offset) : '0;
  assign m_wdata = (r_state == BUSY_I) ? i_wdata :
                   (r_state == BUSY_D) ? d_wdata : '0;

  assign i_gnt  = (r_state == BUSY_I);
  assign d_gnt  = (r_state == BUSY_D);
  assign i_beat = (r_state == BUSY_I) && m_ready;
  assign d_beat = (r_state == BUSY_D) && m_ready;
  assign i_done = (r_state == BUSY_I) && w_last;
  assign d_done = (r_state == BUSY_D) && w_last;
  assign rdata  = w_beat ? m_rdata : '0;

endmodule

// File: tb/tb_fsb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fsb_arbiter
//
// Self-checking bench for fsb_arbiter (BLOCK_WORDS=4, 32-bit address/data).
// A transaction-level model tracks the current owner, its aligned block base
// and the number of beats done. One compare process checks every DUT output
// against that model on each falling edge. Directed scenarios add
// hand-computed literal expectations. A long randomized phase then drives
// protocol-following requesters, random memory stalls and aborts.
// ---------------------------------------------------------------------------
module tb_fsb_arbiter;

  localparam int BW = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        abort_bus;
  logic        i_req, d_req, i_wen, d_wen;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_gnt, d_gnt, i_beat, d_beat, i_done, d_done;
  logic [31:0] rdata;
  logic        m_req, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  fsb_arbiter #(
    .BLOCK_WORDS(BW),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .CLK(CLK), .nRST(nRST), .abort_bus(abort_bus),
    .i_req(i_req), .d_req(d_req), .i_wen(i_wen), .d_wen(d_wen),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_beat(i_beat), .d_beat(d_beat),
    .i_done(i_done), .d_done(d_done), .rdata(rdata),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 CLK = ~CLK;

  // Compares one observed value against its expected value and reports it.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mOwner: 0 = nobody, 1 = icache, 2 = dcache. mLast is the previous winner.
  int          mOwner;
  int          mBeat;
  int          mLast;
  logic [31:0] mBase;
  logic        mWen;

  function automatic int winner();
    if (i_req && d_req) begin
`ifdef FSB_ARB_ROUND_ROBIN_EN
      return (mLast == 1) ? 2 : 1;
`else
      return 2;
`endif
    end
    return d_req ? 2 : 1;
  endfunction

  function automatic logic [31:0] blockBase(input logic [31:0] a);
    return a - (a % 32'(BW * 4));
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mOwner <= 0;
      mBeat  <= 0;
      mLast  <= 1;
      mBase  <= '0;
      mWen   <= 1'b0;
    end else if (mOwner == 0) begin
      if (!abort_bus && (i_req || d_req)) begin
        mOwner <= winner();
        mLast  <= winner();
        mBase  <= blockBase((winner() == 2) ? d_addr : i_addr);
        mWen   <= (winner() == 2) ? d_wen : i_wen;
        mBeat  <= 0;
      end
    end else if (m_ready && (mBeat == BW - 1)) begin
      mOwner <= 0;
    end else if (abort_bus) begin
      mOwner <= 0;
    end else if (m_ready) begin
      mBeat <= mBeat + 1;
    end
  end

  // The single per-cycle compare process.
  always @(negedge CLK) begin
    checkOutput("m_req",   m_req,   mOwner != 0);
    checkOutput("m_wen",   m_wen,   (mOwner != 0) && mWen);
    checkOutput("m_addr",  m_addr,  (mOwner != 0) ? mBase + 32'(4 * mBeat) : 32'h0);
    checkOutput("m_wdata", m_wdata, (mOwner == 1) ? i_wdata : (mOwner == 2) ? d_wdata : 32'h0);
    checkOutput("i_gnt",   i_gnt,   mOwner == 1);
    checkOutput("d_gnt",   d_gnt,   mOwner == 2);
    checkOutput("i_beat",  i_beat,  (mOwner == 1) && m_ready);
    checkOutput("d_beat",  d_beat,  (mOwner == 2) && m_ready);
    checkOutput("i_done",  i_done,  (mOwner == 1) && m_ready && (mBeat == BW - 1));
    checkOutput("d_done",  d_done,  (mOwner == 2) && m_ready && (mBeat == BW - 1));
    if (mOwner == 0)
      checkOutput("rdata_idle", rdata, 32'h0);
    else if (m_ready)
      checkOutput("rdata_beat", rdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  // Advances one cycle and drives the request/memory inputs just after the edge.
  task automatic applyStimulus(input logic iReq, input logic iWen, input logic [31:0] iAddr,
                               input logic dReq, input logic dWen, input logic [31:0] dAddr,
                               input logic mReady, input logic abort);
    @(posedge CLK);
    #1;
    i_req     = iReq;
    i_wen     = iWen;
    i_addr    = iAddr;
    d_req     = dReq;
    d_wen     = dWen;
    d_addr    = dAddr;
    m_ready   = mReady;
    abort_bus = abort;
    i_wdata   = $urandom;
    d_wdata   = $urandom;
    m_rdata   = $urandom;
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1;
    {i_req, d_req, i_wen, d_wen, abort_bus, m_ready} = '0;
    nRST = 1'b0;
    #3;
    nRST = 1'b1;
  endtask

  logic [31:0] t1Addr [4] = '{32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C};

  int gq[$];
  int iBeats, iDones, dDones;
  logic prevReq;
  logic rIReq, rDReq, rIWen, rDWen;
  logic [31:0] rIAddr, rDAddr;
  logic obsIGnt, obsDGnt, obsIDone, obsDDone, obsAbort;

  initial begin
    nRST = 1'b0;
    {i_req, d_req, i_wen, d_wen, abort_bus, m_ready} = '0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; m_rdata = '0;

    // Reset state.
    @(negedge CLK);
    checkOutput("rst_m_req", m_req, 0);
    checkOutput("rst_m_addr", m_addr, 0);
    checkOutput("rst_gnt", {i_gnt, d_gnt}, 0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Single dcache fill with zero-wait memory.
    applyStimulus(0, 0, 0, 1, 0, 32'h8000_001C, 1, 0);
    @(negedge CLK);
    checkOutput("t1_idle_first", m_req, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 32'h8000_001C, 1, 0);
      @(negedge CLK);
      checkOutput("t1_addr", m_addr, t1Addr[k]);
      checkOutput("t1_dbeat", d_beat, 1);
      checkOutput("t1_ddone", d_done, k == 3);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checkOutput("t1_idle_after", m_req, 0);

    // icache writeback with a two-cycle stall on beat 1.
    iBeats = 0;
    iDones = 0;
    applyStimulus(1, 1, 32'h0000_1234, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1, 1, 32'h0000_1234, 0, 0, 0, (c != 2) && (c != 3), 0);
      i_wdata = 32'hA0 + 32'(iBeats);
      @(negedge CLK);
      if (c == 2 || c == 3) begin
        checkOutput("t2_addr_hold", m_addr, 32'h0000_1234);
        checkOutput("t2_wdata_hold", m_wdata, 32'hA1);
        checkOutput("t2_wen", m_wen, 1);
      end
      if (i_beat) iBeats++;
      if (i_done) iDones++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checkOutput("t2_beat_count", iBeats, 4);
    checkOutput("t2_done_count", iDones, 1);

    // Both requesters continuously active from reset.
    doReset();
    prevReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 0, 32'h0000_0100, 1, 0, 32'h0000_0200, 1, 0);
      @(negedge CLK);
      if (m_req && !prevReq) gq.push_back(d_gnt ? 2 : 1);
      if (c == 5 || c == 10 || c == 15) checkOutput("t3_idle_gap", m_req, 0);
      prevReq = m_req;
    end
    checkOutput("t3_grant_count", gq.size(), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef FSB_ARB_ROUND_ROBIN_EN
      checkOutput("t3_grant_order", (k < gq.size()) ? gq[k] : 0, (k % 2 == 0) ? 2 : 1);
`else
      checkOutput("t3_grant_order", (k < gq.size()) ? gq[k] : 0, 2);
`endif
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Abort on beat 2 with an icache request pending.
    doReset();
    dDones = 0;
    applyStimulus(1, 0, 32'h0000_0300, 1, 1, 32'h0000_0400, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1, 0, 32'h0000_0300, 1, 1, 32'h0000_0400, 1, c == 3);
      @(negedge CLK);
      if (d_done) dDones++;
    end
    applyStimulus(1, 0, 32'h0000_0300, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checkOutput("t4_mreq_drop", m_req, 0);
    applyStimulus(1, 0, 32'h0000_0300, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checkOutput("t4_i_granted", i_gnt, 1);
    checkOutput("t4_i_addr", m_addr, 32'h0000_0300);
    for (int c = 6; c <= 8; c++) applyStimulus(1, 0, 32'h0000_0300, 0, 0, 0, 1, 0);
    checkOutput("t4_no_d_done", dDones, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Abort coincident with the final beat: completion wins.
    applyStimulus(0, 0, 0, 1, 1, 32'h0000_0500, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(0, 0, 0, 1, 1, 32'h0000_0500, 1, c == 4);
      @(negedge CLK);
      if (c == 4) checkOutput("t5_done_with_abort", d_done, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    checkOutput("t5_idle", m_req, 0);

    // Reset asserted mid-burst at beat 1.
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0600, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0600, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0600, 1, 0);
    nRST = 1'b0;
    #1;
    checkOutput("t6_rst_mreq", m_req, 0);
    checkOutput("t6_rst_addr", m_addr, 0);
    checkOutput("t6_rst_gnt", d_gnt, 0);
    checkOutput("t6_rst_beat", d_beat, 0);
    checkOutput("t6_rst_wdata", m_wdata, 0);
    #2 nRST = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 32'h0000_0600, 1, 0);
    @(negedge CLK);
    checkOutput("t6_regrant_gnt", d_gnt, 1);
    checkOutput("t6_regrant_addr", m_addr, 32'h0000_0600);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 1, 0, 32'h0000_0600, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic with requesters that follow the hold-until-done rule.
    rIReq = 0; rDReq = 0; rIWen = 0; rDWen = 0; rIAddr = 0; rDAddr = 0;
    obsIGnt = 0; obsDGnt = 0; obsIDone = 0; obsDDone = 0; obsAbort = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rIReq && obsIGnt && (obsIDone || obsAbort)) rIReq = 0;
      else if (rIReq && obsIGnt && ($urandom_range(63) == 0)) rIReq = 0;
      else if (!rIReq && ($urandom_range(3) == 0)) begin
        rIReq = 1; rIWen = 1'($urandom); rIAddr = $urandom;
      end
      if (rDReq && obsDGnt && (obsDDone || obsAbort)) rDReq = 0;
      else if (rDReq && obsDGnt && ($urandom_range(63) == 0)) rDReq = 0;
      else if (!rDReq && ($urandom_range(3) == 0)) begin
        rDReq = 1; rDWen = 1'($urandom); rDAddr = $urandom;
      end
      applyStimulus(rIReq, rIWen, rIAddr, rDReq, rDWen, rDAddr,
                    $urandom_range(3) != 0, $urandom_range(15) == 0);
      @(negedge CLK);
      obsIGnt = i_gnt; obsDGnt = d_gnt; obsIDone = i_done; obsDDone = d_done;
      obsAbort = abort_bus;
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
